// File: rtl/tdm_pkg.sv
// Shared definitions for the TDM channel mux/demux pair.
//   tdm_state_t : receive-side framing FSM states
//   WIDTH_DEF   : default per-channel word width
//   CH_X / CH_Y : channel select encodings (same on transmit and receive side)
package tdm_pkg;

   typedef enum logic [1:0] {
      WAIT_SYNC = 2'd0,
      EXPECT_Y  = 2'd1,
      EXPECT_X  = 2'd2
   } tdm_state_t;

   localparam int   WIDTH_DEF = 3;
   localparam logic CH_X      = 1'b0;
   localparam logic CH_Y      = 1'b1;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: increments on inc, sticks at all-ones, clears only on reset.
//   clk   : rising-edge clock
//   rst   : asynchronous active-high reset
//   inc   : count one event this cycle
//   count : current count (registered)
module sat_counter #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         inc,
   output logic [W-1:0] count
);

   logic [W-1:0] r_count;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         r_count <= '0;
      else if (inc && (r_count != {W{1'b1}}))
         r_count <= r_count + 1'b1;
   end

   assign count = r_count;

endmodule

// File: rtl/tdm_demux_1_to_2.sv
// Receive side of the 2-to-1 TDM channel mux. Locks onto the start-of-frame
// marker, steers alternating slots into X and Y, publishes a coherent {X,Y}
// pair once per frame and counts framing errors.
//   CLOCK_50   : rising-edge clock
//   reset      : asynchronous active-high reset
//   din        : shared-bus word, din_valid qualifies it, sof marks the X slot
//   x_out/y_out, x_valid/y_valid : last captured words and update pulses
//   pair_x/pair_y, pair_valid    : last complete frame and its update pulse
//   sel_out    : channel last written (CH_X / CH_Y)
//   locked     : FSM is framed (EXPECT_Y or EXPECT_X)
//   err_cnt    : saturating framing-error count
module tdm_demux_1_to_2
   import tdm_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF,
   parameter int ERR_W = 4
) (
   input  logic             CLOCK_50,
   input  logic             reset,
   input  logic [WIDTH-1:0] din,
   input  logic             din_valid,
   input  logic             sof,
   output logic [WIDTH-1:0] x_out,
   output logic [WIDTH-1:0] y_out,
   output logic             x_valid,
   output logic             y_valid,
   output logic [WIDTH-1:0] pair_x,
   output logic [WIDTH-1:0] pair_y,
   output logic             pair_valid,
   output logic             sel_out,
   output logic             locked,
   output logic [ERR_W-1:0] err_cnt
);

   tdm_state_t       r_state;
   logic [WIDTH-1:0] r_x_out, r_y_out, r_pair_x, r_pair_y;
   logic             r_x_valid, r_y_valid, r_pair_valid, r_sel, r_locked;
   logic             w_err_inc;

   // Framing error: a second sof while a Y slot is due, or a non-sof word
   // where the next frame start should be.
   assign w_err_inc = din_valid &&
                      (((r_state == EXPECT_Y) &&  sof) ||
                       ((r_state == EXPECT_X) && !sof));

   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) begin
         r_state      <= WAIT_SYNC;
         r_x_out      <= '0;
         r_y_out      <= '0;
         r_pair_x     <= '0;
         r_pair_y     <= '0;
         r_x_valid    <= 1'b0;
         r_y_valid    <= 1'b0;
         r_pair_valid <= 1'b0;
         r_sel        <= 1'b0;
         r_locked     <= 1'b0;
      end else begin
         r_x_valid    <= 1'b0;
         r_y_valid    <= 1'b0;
         r_pair_valid <= 1'b0;
         if (din_valid) begin
            case (r_state)
               WAIT_SYNC: begin
                  if (sof) begin
                     r_x_out   <= din;
                     r_x_valid <= 1'b1;
                     r_sel     <= CH_X;
                     r_state   <= EXPECT_Y;
                     r_locked  <= 1'b1;
                  end
               end
               EXPECT_Y: begin
                  if (sof) begin
                     // Y slot went missing: restart the frame on this word.
                     r_x_out   <= din;
                     r_x_valid <= 1'b1;
                     r_sel     <= CH_X;
                  end else begin
                     r_y_out      <= din;
                     r_y_valid    <= 1'b1;
                     r_sel        <= CH_Y;
                     // x_out still holds this frame's X, so the pair is coherent.
                     r_pair_x     <= r_x_out;
                     r_pair_y     <= din;
                     r_pair_valid <= 1'b1;
                     r_state      <= EXPECT_X;
                  end
               end
               EXPECT_X: begin
                  if (sof) begin
                     r_x_out   <= din;
                     r_x_valid <= 1'b1;
                     r_sel     <= CH_X;
                     r_state   <= EXPECT_Y;
                  end else begin
                     r_state  <= WAIT_SYNC;
                     r_locked <= 1'b0;
                  end
               end
               default: begin
                  r_state  <= WAIT_SYNC;
                  r_locked <= 1'b0;
               end
            endcase
         end
      end
   end

   sat_counter #(.W(ERR_W)) u_err_cnt (
      .clk   (CLOCK_50),
      .rst   (reset),
      .inc   (w_err_inc),
      .count (err_cnt)
   );

   assign x_out      = r_x_out;
   assign y_out      = r_y_out;
   assign x_valid    = r_x_valid;
   assign y_valid    = r_y_valid;
   assign pair_x     = r_pair_x;
   assign pair_y     = r_pair_y;
   assign pair_valid = r_pair_valid;
   assign sel_out    = r_sel;
   assign locked     = r_locked;

endmodule

// File: tb/tb_tdm_demux_1_to_2.sv
module tb_tdm_demux_1_to_2;

   localparam int WIDTH = 3;
   localparam int ERR_W = 4;

   typedef struct packed {
      logic [WIDTH-1:0] x_out;
      logic [WIDTH-1:0] y_out;
      logic             x_valid;
      logic             y_valid;
      logic [WIDTH-1:0] pair_x;
      logic [WIDTH-1:0] pair_y;
      logic             pair_valid;
      logic             sel_out;
      logic             locked;
      logic [ERR_W-1:0] err_cnt;
   } obs_t;

   logic             CLOCK_50 = 1'b0;
   logic             reset;
   logic [WIDTH-1:0] din;
   logic             din_valid, sof;
   logic [WIDTH-1:0] x_out, y_out, pair_x, pair_y;
   logic             x_valid, y_valid, pair_valid, sel_out, locked;
   logic [ERR_W-1:0] err_cnt;

   int vectors = 0;
   int miscompares = 0;

   obs_t exp_q[$];
   obs_t got_q[$];

   // Reference model of the demux, written from the behavioural description.
   // 0 = WAIT_SYNC, 1 = EXPECT_Y, 2 = EXPECT_X
   int   m_state;
   obs_t m;

   always #10 CLOCK_50 = ~CLOCK_50;

   tdm_demux_1_to_2 #(.WIDTH(WIDTH), .ERR_W(ERR_W)) dut (
      .CLOCK_50   (CLOCK_50),
      .reset      (reset),
      .din        (din),
      .din_valid  (din_valid),
      .sof        (sof),
      .x_out      (x_out),
      .y_out      (y_out),
      .x_valid    (x_valid),
      .y_valid    (y_valid),
      .pair_x     (pair_x),
      .pair_y     (pair_y),
      .pair_valid (pair_valid),
      .sel_out    (sel_out),
      .locked     (locked),
      .err_cnt    (err_cnt)
   );

   function automatic obs_t sample();
      obs_t o;
      o.x_out = x_out;   o.y_out = y_out;
      o.x_valid = x_valid; o.y_valid = y_valid;
      o.pair_x = pair_x; o.pair_y = pair_y; o.pair_valid = pair_valid;
      o.sel_out = sel_out; o.locked = locked; o.err_cnt = err_cnt;
      return o;
   endfunction

   function automatic void model_reset();
      m_state = 0;
      m = '0;
   endfunction

   function automatic void model_err();
      if (m.err_cnt != {ERR_W{1'b1}}) m.err_cnt = m.err_cnt + 1'b1;
   endfunction

   // Drive one cycle (called just after a falling edge), push the expected
   // post-edge outputs, then capture what the DUT shows at the next falling edge.
   task automatic beat(input logic v, input logic s, input logic [WIDTH-1:0] d);
      din_valid = v; sof = s; din = d;
      m.x_valid = 1'b0; m.y_valid = 1'b0; m.pair_valid = 1'b0;
      if (v) begin
         if (m_state == 0) begin
            if (s) begin
               m.x_out = d; m.x_valid = 1'b1; m.sel_out = 1'b0; m_state = 1;
            end
         end else if (m_state == 1) begin
            if (s) begin
               model_err();
               m.x_out = d; m.x_valid = 1'b1; m.sel_out = 1'b0;
            end else begin
               m.pair_x = m.x_out; m.pair_y = d; m.pair_valid = 1'b1;
               m.y_out = d; m.y_valid = 1'b1; m.sel_out = 1'b1; m_state = 2;
            end
         end else begin
            if (s) begin
               m.x_out = d; m.x_valid = 1'b1; m.sel_out = 1'b0; m_state = 1;
            end else begin
               model_err(); m_state = 0;
            end
         end
      end
      m.locked = (m_state != 0);
      exp_q.push_back(m);
      @(posedge CLOCK_50);
      @(negedge CLOCK_50);
      got_q.push_back(sample());
   endtask

   task automatic test_reset();
      obs_t g;
      din_valid = 1'b0; sof = 1'b0; din = '0;
      reset = 1'b1;
      model_reset();
      repeat (2) @(negedge CLOCK_50);
      g = sample();
      vectors++;
      if (g !== obs_t'(0)) begin
         miscompares++;
         $display("FAIL reset_init got=%h exp=%h", g, obs_t'(0));
      end
      reset = 1'b0;
      beat(1, 1, 3'd5);
      beat(1, 0, 3'd7);
      beat(0, 0, 3'd0);
      while (exp_q.size() > 0) begin
         obs_t e;
         e = exp_q.pop_front(); g = got_q.pop_front();
         vectors++;
         if (g !== e) begin
            miscompares++;
            $display("FAIL reset_prefill got=%h exp=%h", g, e);
         end
      end
      // Assert reset between edges: outputs must clear without a clock edge.
      #3 reset = 1'b1;
      model_reset();
      #1 g = sample();
      vectors++;
      if (g !== obs_t'(0)) begin
         miscompares++;
         $display("FAIL reset_async got=%h exp=%h", g, obs_t'(0));
      end
      @(negedge CLOCK_50);
      reset = 1'b0;
   endtask

   task automatic test_frame();
      obs_t e, g;
      beat(1, 1, 3'd3);
      beat(1, 0, 3'd6);
      beat(0, 1, 3'd1);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); g = got_q.pop_front();
         vectors++;
         if (g !== e) begin
            miscompares++;
            $display("FAIL frame got=%h exp=%h", g, e);
         end
      end
   endtask

   task automatic test_lost_sync();
      obs_t e, g;
      beat(1, 0, 3'd1);
      beat(0, 0, 3'd0);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); g = got_q.pop_front();
         vectors++;
         if (g !== e) begin
            miscompares++;
            $display("FAIL lost_sync got=%h exp=%h", g, e);
         end
      end
   endtask

   task automatic test_wait_sync_idle();
      obs_t e, g;
      beat(1, 0, 3'd7);
      for (int i = 0; i < 5; i++) beat(0, i[0] == 1'b0, 3'(i + 2));
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); g = got_q.pop_front();
         vectors++;
         if (g !== e) begin
            miscompares++;
            $display("FAIL wait_sync_idle got=%h exp=%h", g, e);
         end
      end
   endtask

   task automatic test_missing_y();
      obs_t e, g;
      beat(1, 1, 3'd5);
      beat(1, 1, 3'd2);
      beat(1, 0, 3'd4);
      beat(1, 1, 3'd6);
      beat(0, 0, 3'd0);
      beat(1, 0, 3'd3);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); g = got_q.pop_front();
         vectors++;
         if (g !== e) begin
            miscompares++;
            $display("FAIL missing_y got=%h exp=%h", g, e);
         end
      end
   endtask

   task automatic test_saturate();
      obs_t e, g;
      for (int i = 0; i < 21; i++) beat(1, 1, 3'(i));
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); g = got_q.pop_front();
         vectors++;
         if (g !== e) begin
            miscompares++;
            $display("FAIL saturate got=%h exp=%h", g, e);
         end
      end
      vectors++;
      if (err_cnt !== 4'd15) begin
         miscompares++;
         $display("FAIL err_cnt_ceiling got=%0d exp=15", err_cnt);
      end
   endtask

   initial begin
      fork
         begin
            test_reset();
            test_frame();
            test_lost_sync();
            test_wait_sync_idle();
            test_missing_y();
            test_saturate();
         end
         begin
            #200000;
            $display("FAIL timeout got=running exp=done");
            $fatal(1, "timeout");
         end
      join_any
      disable fork;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
